// File: rtl/cordic_vec_arbiter.sv
// Shares one cordic_vectoring core among NREQ requesters: round-robin issue,
// in-order tag FIFO, and routing of each core result back to its owner.
module cordic_vec_arbiter #(
    parameter int NREQ      = 4,
    parameter int XY_W      = 16,
    parameter int ANGLE_W   = 32,
    parameter int TAG_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*XY_W-1:0]          req_x,
    input  logic [NREQ*XY_W-1:0]          req_y,
    output logic [NREQ-1:0]               rsp_valid,
    input  logic [NREQ-1:0]               rsp_ready,
    output logic [XY_W-1:0]               rsp_mag,
    output logic [ANGLE_W-1:0]            rsp_theta,
    output logic                          core_in_valid,
    input  logic                          core_in_ready,
    output logic [XY_W-1:0]               core_x,
    output logic [XY_W-1:0]               core_y,
    input  logic                          core_out_valid,
    output logic                          core_out_ready,
    input  logic [XY_W-1:0]               core_mag,
    input  logic [ANGLE_W-1:0]            core_theta,
    output logic [$clog2(TAG_DEPTH):0]    outstanding,
    output logic                          err_orphan
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  tag_q [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_orphan_q, err_orphan_d;

    logic [ID_W-1:0]  gnt;
    logic [ID_W:0]    idx;
    logic [ID_W-1:0]  head;
    logic [NREQ-1:0]  head_rdy;
    logic             any_valid, fifo_full, fifo_empty;
    logic             issue_ok, rsp_ok, fire_in, pop, orphan;

    assign fifo_full  = (count_q == CNT_W'(TAG_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign any_valid  = |req_valid;
    assign head       = tag_q[rd_ptr_q];

    // Walk the ring from the far end back to rr_ptr so the nearest valid wins.
    always_comb begin
        gnt = rr_ptr_q;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NREQ)) begin
                idx = idx - (ID_W+1)'(NREQ);
            end
            if (req_valid[idx[ID_W-1:0]]) begin
                gnt = idx[ID_W-1:0];
            end
        end
    end

    assign rr_ptr_d = (gnt == ID_W'(NREQ - 1)) ? '0 : gnt + ID_W'(1);

    // Handshake outputs are forced low while reset is held, independent of state.
    assign core_in_valid = rst_n && any_valid && !fifo_full;
    assign issue_ok      = core_in_valid && core_in_ready;
    assign fire_in       = issue_ok;
    assign core_x        = req_x[gnt*XY_W +: XY_W];
    assign core_y        = req_y[gnt*XY_W +: XY_W];

    assign rsp_ok         = rst_n && core_out_valid && !fifo_empty;
    assign core_out_ready = rst_n && (fifo_empty || (|head_rdy));
    assign rsp_mag        = core_mag;
    assign rsp_theta      = core_theta;

    assign pop    = core_out_valid && core_out_ready && !fifo_empty;
    assign orphan = core_out_valid && fifo_empty;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign req_ready[i] = issue_ok && (gnt == ID_W'(i));
        assign rsp_valid[i] = rsp_ok && (head == ID_W'(i));
        assign head_rdy[i]  = (head == ID_W'(i)) && rsp_ready[i];
    end

    always_comb begin
        count_d = count_q;
        case ({fire_in, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    assign err_orphan_d = err_orphan_q || orphan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_orphan_q <= 1'b0;
            for (int t = 0; t < TAG_DEPTH; t++) begin
                tag_q[t] <= '0;
            end
        end else begin
            if (fire_in) begin
                tag_q[wr_ptr_q] <= gnt;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                rr_ptr_q        <= rr_ptr_d;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q      <= count_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign outstanding = count_q;
    assign err_orphan  = err_orphan_q;

endmodule
